// File: rtl/row_loader_pkg.sv
// row_loader_pkg: shared types and helpers for the row_loader feeder.
//   state_t        : loader FSM states (IDLE, FILL, ISSUE, DRAIN)
//   rot_t          : row recycle mode applied between groups
//   BEATS_PER_ROW  : beats per row at the default geometry
//   ROW_IDX_W      : width of the row select (rows 1..3 encoded 0..2)
//   rows_to_load() : number of rows a group must fetch from the stream
// Optional feature macro: ROW_LOADER_REUSE_EN (row recycling between groups).
package row_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_S1   = 2'd1,
    ROT_S2   = 2'd2
  } rot_t;

  localparam int DEF_SHIFT_REGS_NUM = 70;
  localparam int DEF_PIX_PER_BEAT   = 10;
  localparam int BEATS_PER_ROW      = DEF_SHIFT_REGS_NUM / DEF_PIX_PER_BEAT;
  localparam int ROW_IDX_W          = 2;

  // Rows fetched for a group. The first group of a job always needs all three;
  // later groups can reuse rows already held when recycling is built in.
  function automatic logic [1:0] rows_to_load(input logic [3:0] s,
                                              input logic       first_group);
    logic [1:0] n;
    logic       unused_args;
    n           = 2'd3;
    unused_args = ^{s, first_group};
`ifdef ROW_LOADER_REUSE_EN
    if (!first_group) begin
      if (s == 4'd1)      n = 2'd1;
      else if (s == 4'd2) n = 2'd2;
    end
`endif
    return n;
  endfunction

endpackage

// File: rtl/row_buffer_bank.sv
// row_buffer_bank: three row registers of SHIFT_REGS_NUM pixels each.
//   clk, reset      : clock, asynchronous active-high reset (clears all rows)
//   wr_en           : write one beat into the selected row
//   wr_row          : target row (0 = row 1, 1 = row 2, 2 = row 3)
//   wr_beat         : beat slot within the row (bytes beat*PIX_PER_BEAT ..)
//   wr_data         : beat payload, pixel p in byte p
//   rot_en/rot_mode : recycle rows between groups (ROT_S1 shifts up by one,
//                     ROT_S2 moves row 3 into row 1)
//   row_1..row_3    : row contents, pixel i in byte i
module row_buffer_bank
  import row_loader_pkg::*;
#(
  parameter  int SHIFT_REGS_NUM = DEF_SHIFT_REGS_NUM,
  parameter  int PIX_PER_BEAT   = DEF_PIX_PER_BEAT,
  localparam int ROW_W          = SHIFT_REGS_NUM * 8,
  localparam int BEAT_W         = PIX_PER_BEAT * 8,
  localparam int BPR            = SHIFT_REGS_NUM / PIX_PER_BEAT,
  localparam int BEAT_IDX_W     = (BPR > 1) ? $clog2(BPR) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ROW_IDX_W-1:0]  wr_row,
  input  logic [BEAT_IDX_W-1:0] wr_beat,
  input  logic [BEAT_W-1:0]     wr_data,
  input  logic                  rot_en,
  input  rot_t                  rot_mode,
  output logic [ROW_W-1:0]      row_1,
  output logic [ROW_W-1:0]      row_2,
  output logic [ROW_W-1:0]      row_3
);

  // Rotation happens only on the ISSUE->FILL edge and writes only in FILL,
  // so the two never coincide; rotation is given priority regardless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_1 <= '0;
      row_2 <= '0;
      row_3 <= '0;
    end else if (rot_en) begin
      case (rot_mode)
        ROT_S1: begin
          row_1 <= row_2;
          row_2 <= row_3;
        end
        ROT_S2:  row_1 <= row_3;
        default: ;
      endcase
    end else if (wr_en) begin
      for (int b = 0; b < BPR; b++) begin
        if (wr_beat == BEAT_IDX_W'(b)) begin
          case (wr_row)
            2'd0:    row_1[b*BEAT_W +: BEAT_W] <= wr_data;
            2'd1:    row_2[b*BEAT_W +: BEAT_W] <= wr_data;
            2'd2:    row_3[b*BEAT_W +: BEAT_W] <= wr_data;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/row_loader.sv
// row_loader: assembles three rows of pixels from a beat stream and issues a
// load strobe to the 3-row shift stage, once per row group of a job.
//   clk, reset          : clock, asynchronous active-high reset
//   k, s                : kernel size / stride (shared with the shift stage)
//   job_start           : one-cycle launch, honoured only when idle
//   job_groups          : number of row groups, sampled on job_start
//   pix_valid/pix_ready : beat handshake; pix_data pixel p in byte p
//   row_regs_1..3       : assembled rows, pixel i in byte i
//   shift_start         : one-cycle load strobe (driven from flops only)
//   re_fm_end           : end-of-shift pulse from the shift stage
//   busy                : state is not IDLE
//   job_done            : one-cycle registered completion pulse
// Optional feature macro: ROW_LOADER_REUSE_EN (recycle rows between groups).
module row_loader
  import row_loader_pkg::*;
#(
  parameter  int SHIFT_REGS_NUM = DEF_SHIFT_REGS_NUM,
  parameter  int PIX_PER_BEAT   = DEF_PIX_PER_BEAT,
  localparam int ROW_W          = SHIFT_REGS_NUM * 8,
  localparam int BEAT_W         = PIX_PER_BEAT * 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        k,
  input  logic [3:0]        s,
  input  logic              job_start,
  input  logic [15:0]       job_groups,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [BEAT_W-1:0] pix_data,
  output logic [ROW_W-1:0]  row_regs_1,
  output logic [ROW_W-1:0]  row_regs_2,
  output logic [ROW_W-1:0]  row_regs_3,
  output logic              shift_start,
  input  logic              re_fm_end,
  output logic              busy,
  output logic              job_done
);

  localparam int BPR        = SHIFT_REGS_NUM / PIX_PER_BEAT;
  localparam int BEAT_IDX_W = (BPR > 1) ? $clog2(BPR) : 1;

  state_t                state_q, state_d;
  logic [3:0]            gap_cnt_q;
  logic [15:0]           group_cnt_q;
  logic [15:0]           groups_q;
  logic [ROW_IDX_W-1:0]  row_idx_q;
  logic [BEAT_IDX_W-1:0] beat_idx_q;
  logic                  job_done_q;

  logic accept, last_beat, fire, last_group, start_job, zero_job;
  logic rot_en;
  rot_t rot_mode;

  assign accept     = (state_q == FILL) && pix_valid;
  assign last_beat  = accept && (row_idx_q == ROW_IDX_W'(2)) &&
                      (beat_idx_q == BEAT_IDX_W'(BPR - 1));
  // gap_cnt <= 1 lets the next load land on the shift stage's final window
  // cycle, so back-to-back groups need no idle cycle in between.
  assign fire       = (state_q == ISSUE) && (gap_cnt_q <= 4'd1);
  assign last_group = ((group_cnt_q + 16'd1) == groups_q);
  assign start_job  = (state_q == IDLE) && job_start && (job_groups != 16'd0);
  assign zero_job   = (state_q == IDLE) && job_start && (job_groups == 16'd0);

`ifdef ROW_LOADER_REUSE_EN
  assign rot_en   = fire && !last_group && (rows_to_load(s, 1'b0) != 2'd3);
  assign rot_mode = (s == 4'd1) ? ROT_S1 : ((s == 4'd2) ? ROT_S2 : ROT_NONE);
`else
  assign rot_en   = 1'b0;
  assign rot_mode = ROT_NONE;
`endif

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state and decoded outputs ----
  always_comb begin
    state_d     = state_q;
    pix_ready   = 1'b0;
    shift_start = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_job) state_d = FILL;
      end
      FILL: begin
        pix_ready = 1'b1;
        if (last_beat) state_d = ISSUE;
      end
      ISSUE: begin
        if (fire) begin
          shift_start = 1'b1;
          state_d     = last_group ? DRAIN : FILL;
        end
      end
      DRAIN: begin
        if (re_fm_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- Counters and completion pulse ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt_q   <= '0;
      group_cnt_q <= '0;
      groups_q    <= '0;
      row_idx_q   <= '0;
      beat_idx_q  <= '0;
      job_done_q  <= 1'b0;
    end else begin
      job_done_q <= zero_job || ((state_q == DRAIN) && re_fm_end);

      if (fire)                   gap_cnt_q <= k;
      else if (start_job)         gap_cnt_q <= '0;
      else if (gap_cnt_q != 4'd0) gap_cnt_q <= gap_cnt_q - 4'd1;

      if (start_job) begin
        group_cnt_q <= '0;
        groups_q    <= job_groups;
        beat_idx_q  <= '0;
        row_idx_q   <= ROW_IDX_W'(2'd3 - rows_to_load(s, 1'b1));
      end else if (fire) begin
        group_cnt_q <= group_cnt_q + 16'd1;
        beat_idx_q  <= '0;
        // Groups after the first may skip rows that were recycled.
        row_idx_q   <= ROW_IDX_W'(2'd3 - rows_to_load(s, 1'b0));
      end else if (accept) begin
        if (beat_idx_q == BEAT_IDX_W'(BPR - 1)) begin
          beat_idx_q <= '0;
          row_idx_q  <= row_idx_q + ROW_IDX_W'(1);
        end else begin
          beat_idx_q <= beat_idx_q + BEAT_IDX_W'(1);
        end
      end
    end
  end

  assign job_done = job_done_q;

  row_buffer_bank #(
    .SHIFT_REGS_NUM (SHIFT_REGS_NUM),
    .PIX_PER_BEAT   (PIX_PER_BEAT)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept),
    .wr_row   (row_idx_q),
    .wr_beat  (beat_idx_q),
    .wr_data  (pix_data),
    .rot_en   (rot_en),
    .rot_mode (rot_mode),
    .row_1    (row_regs_1),
    .row_2    (row_regs_2),
    .row_3    (row_regs_3)
  );

endmodule

// File: doc/row_loader.md
# row_loader

Upstream feeder for the 3-row shift-register stage of the convolution datapath. Accepts a beat stream of feature-map pixels from the on-chip buffer and assembles three rows of `SHIFT_REGS_NUM` pixels into the `row_regs_1..3` buses. It then pulses `shift_start` no earlier than the shift stage can accept a new load, and repeats for a programmed number of row groups, signalling `job_done` after the last group drains.

## Interface
- `SHIFT_REGS_NUM`, 70: pixels per row register (8 bit each).
- `PIX_PER_BEAT`, 10: pixels per input beat; must divide `SHIFT_REGS_NUM` (`BEATS_PER_ROW` = 7 at defaults).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `k` in 4: kernel size; same value the shift stage receives.
- `s` in 4: stride; same value the shift stage receives.
- `job_start` in 1: one-cycle job launch; honoured only in IDLE.
- `job_groups` in 16: row groups in the job; sampled on `job_start`.
- `pix_valid` in 1: input beat valid.
- `pix_ready` out 1: input beat ready.
- `pix_data` in `PIX_PER_BEAT*8`: pixel p of the beat is in byte p, LSB-first.
- `row_regs_1`, `row_regs_2`, `row_regs_3` out `SHIFT_REGS_NUM*8` each: assembled rows; pixel i is in byte i.
- `shift_start` out 1: one-cycle load strobe to the shift stage.
- `re_fm_end` in 1: end-of-shift pulse from the shift stage.
- `busy` out 1: asserted whenever state is not IDLE.
- `job_done` out 1: one-cycle job completion pulse.

## Operation
- **Reset values:** all outputs 0, every row register 0, state IDLE, all counters 0.
- **FSM states:** IDLE, FILL, ISSUE, DRAIN.
- **IDLE**
  - `job_start` with `job_groups`≠0: clear counters, go to FILL.
  - `job_start` with `job_groups`=0: pulse `job_done` next cycle, stay in IDLE.
  - `pix_ready`=0.
- **FILL**
  - `pix_ready`=1; a beat transfers when `pix_valid`&&`pix_ready` at a rising edge.
  - Beat b of the current row writes bytes [b·PIX_PER_BEAT, +PIX_PER_BEAT) of that row.
  - Row order within a group: row 1, then row 2, then row 3.
  - After the last required beat, go to ISSUE.
- **ISSUE**
  - `pix_ready`=0.
  - `shift_start`=1 when `gap_cnt`≤1; same edge increments `group_cnt`.
  - Next state is DRAIN if this was group `job_groups`, otherwise FILL.
- **DRAIN**
  - Wait for `re_fm_end`, then pulse `job_done` and return to IDLE.
- **Gap counter:** `gap_cnt` (4 bit) loads `k` on every `shift_start` edge and decrements while nonzero.
  - The next `shift_start` therefore lands no earlier than the shift stage's final window cycle, which permits back-to-back loads.
- `row_regs_*` hold their value through the `shift_start` cycle. They are overwritten only by later FILL beats.
- `job_start` while `busy` is ignored.
- `pix_valid` outside FILL is ignored.
- `k`/`s` must be stable for the whole job; this is not checked.
- `group_cnt` is 16 bit and does not wrap, because the job terminates at `job_groups`.

## Timing
- `shift_start` is driven only from flops (state, `gap_cnt`); no combinational path from any input.
- `shift_start` rises in the cycle after the last accepted beat of a group, unless held by `gap_cnt`.
- FILL re-enters the cycle after `shift_start`; minimum group period is rows·`BEATS_PER_ROW`+1 cycles.
- `job_done` is registered: it is asserted the cycle after `re_fm_end` is sampled in DRAIN.
- Asynchronous reset mid-job drops `pix_ready`, `shift_start`, `busy` and `job_done` to 0 immediately and clears all row data. A partially received beat sequence is discarded.

## Configuration
- `ROW_LOADER_REUSE_EN` defined: for groups after the first, rows are recycled on entry to FILL.
  - `s`=1: row1←row2, row2←row3; load row 3 only (7 beats).
  - `s`=2: row1←row3; load rows 2 and 3 (14 beats).
  - Any other `s`: load all 3 rows.
- `ROW_LOADER_REUSE_EN` undefined: every group loads all 3 rows (21 beats) and `s` is unused.

## Structure
- Package `row_loader_pkg` holds:
  - the state enum;
  - `BEATS_PER_ROW` and the row-index width;
  - the `rows_to_load(s, first_group)` function.
- One sub-module, `row_buffer_bank`: three row registers with beat-write port, row select and recycle/rotate control.
- FSM and counters live in the top level.

## Test plan
Bench pairs the DUT with the shift-register stage (or a cycle-exact model of it). Defaults throughout.

1. **Single group:** `job_groups`=1, `k`=3, `s`=1, 21 back-to-back beats, pixel value = stream index mod 256.
   - Row 1 byte i = i, row 2 byte i = 70+i, row 3 byte i = (140+i) mod 256.
   - `shift_start` fires exactly once, 1 cycle after beat 21.
   - `job_done` fires 1 cycle after `re_fm_end`.
2. **Continuous stream:** `job_groups`=3, `k`=1, `pix_valid` held high.
   - `shift_start` pulses are spaced exactly 22 cycles apart.
   - `busy` stays 1 until `job_done`.
3. **Zero groups:** `job_groups`=0.
   - `job_done` the next cycle.
   - No `shift_start`; `pix_ready` remains 0.
4. **Backpressure:** `pix_valid` toggled 1-0-1-0.
   - Row contents identical to scenario 1.
   - `shift_start` delayed to 1 cycle after the 21st accepted beat.
5. **Reset mid-FILL:** assert `reset` after 10 beats.
   - All outputs and row bytes are 0 in the same cycle.
   - A fresh scenario-1 job then passes.
6. **Reuse (`ROW_LOADER_REUSE_EN` defined):** `s`=1, `k`=9, `job_groups`=2.
   - Second group takes 7 beats; old row 2 moves to row 1 and old row 3 to row 2.
   - Second `shift_start` is exactly 9 cycles after the first.
